// File: rtl/axis_stream_fifo_if.sv
// AXI-Stream <-> accelerator core data-path interface: FWFT FIFOs in both directions,
// inbound frame-length checking and per-direction frame counters.
module axis_stream_fifo_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_DEPTH   = 4,
    parameter int FRAME_BEATS = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  S_AXIS_TLAST,
    output logic [DATA_WIDTH-1:0] acc_in_data,
    output logic                  acc_in_valid,
    output logic                  acc_in_last,
    input  logic                  acc_in_ready,
    input  logic [DATA_WIDTH-1:0] acc_out_data,
    input  logic                  acc_out_valid,
    input  logic                  acc_out_last,
    output logic                  acc_out_ready,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic [15:0]           in_frame_cnt,
    output logic [15:0]           out_frame_cnt,
    output logic                  frame_err,
    input  logic                  err_clr
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int BIW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [IAW:0]   IN_FULL  = (IAW+1)'(IN_DEPTH);
    localparam logic [OAW:0]   OUT_FULL = (OAW+1)'(OUT_DEPTH);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(FRAME_BEATS - 1);

    logic [DATA_WIDTH:0] in_mem  [IN_DEPTH];
    logic [DATA_WIDTH:0] out_mem [OUT_DEPTH];

    logic [IAW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [IAW:0]   in_cnt_q, in_cnt_d;
    logic [OAW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [OAW:0]   out_cnt_q, out_cnt_d;
    logic [BIW-1:0] beat_idx_q, beat_idx_d;
    logic [15:0]    in_frames_q, in_frames_d, out_frames_q, out_frames_d;
    logic           frame_err_q, frame_err_d;
    logic           rdy_en_q;

    logic s_push, s_pop, m_push, m_pop;

    // Readies are held low through reset and come up on the first edge afterwards.
    assign S_AXIS_TREADY = rdy_en_q && (in_cnt_q != IN_FULL);
    assign acc_out_ready = rdy_en_q && (out_cnt_q != OUT_FULL);
    assign acc_in_valid  = (in_cnt_q != '0);
    assign M_AXIS_TVALID = (out_cnt_q != '0);

    assign {acc_in_last, acc_in_data}   = in_mem[in_rd_q];
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = out_mem[out_rd_q];

    assign s_push = S_AXIS_TVALID && S_AXIS_TREADY;
    assign s_pop  = acc_in_valid && acc_in_ready;
    assign m_push = acc_out_valid && acc_out_ready;
    assign m_pop  = M_AXIS_TVALID && M_AXIS_TREADY;

    assign in_frame_cnt  = in_frames_q;
    assign out_frame_cnt = out_frames_q;
    assign frame_err     = frame_err_q;

    always_comb begin
        in_wr_d  = in_wr_q;
        in_rd_d  = in_rd_q;
        in_cnt_d = in_cnt_q;
        if (s_push) in_wr_d = in_wr_q + 1'b1;
        if (s_pop)  in_rd_d = in_rd_q + 1'b1;
        if (s_push && !s_pop)      in_cnt_d = in_cnt_q + 1'b1;
        else if (!s_push && s_pop) in_cnt_d = in_cnt_q - 1'b1;

        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        if (m_push) out_wr_d = out_wr_q + 1'b1;
        if (m_pop)  out_rd_d = out_rd_q + 1'b1;
        if (m_push && !m_pop)      out_cnt_d = out_cnt_q + 1'b1;
        else if (!m_push && m_pop) out_cnt_d = out_cnt_q - 1'b1;
    end

    // A new length error takes priority over a clear on the same edge.
    always_comb begin
        beat_idx_d   = beat_idx_q;
        in_frames_d  = in_frames_q;
        out_frames_d = out_frames_q;
        frame_err_d  = err_clr ? 1'b0 : frame_err_q;
        if (s_push) begin
            if (S_AXIS_TLAST) begin
                if (beat_idx_q != LAST_IDX) frame_err_d = 1'b1;
                beat_idx_d  = '0;
                in_frames_d = in_frames_q + 16'd1;
            end else if (beat_idx_q == LAST_IDX) begin
                frame_err_d = 1'b1;
            end else begin
                beat_idx_d = beat_idx_q + 1'b1;
            end
        end
        if (m_pop && M_AXIS_TLAST) out_frames_d = out_frames_q + 16'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            in_wr_q      <= '0;
            in_rd_q      <= '0;
            in_cnt_q     <= '0;
            out_wr_q     <= '0;
            out_rd_q     <= '0;
            out_cnt_q    <= '0;
            beat_idx_q   <= '0;
            in_frames_q  <= '0;
            out_frames_q <= '0;
            frame_err_q  <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            in_wr_q      <= in_wr_d;
            in_rd_q      <= in_rd_d;
            in_cnt_q     <= in_cnt_d;
            out_wr_q     <= out_wr_d;
            out_rd_q     <= out_rd_d;
            out_cnt_q    <= out_cnt_d;
            beat_idx_q   <= beat_idx_d;
            in_frames_q  <= in_frames_d;
            out_frames_q <= out_frames_d;
            frame_err_q  <= frame_err_d;
            rdy_en_q     <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy counts alone decide what is valid.
    always_ff @(posedge ACLK) begin
        if (s_push) in_mem[in_wr_q]   <= {S_AXIS_TLAST, S_AXIS_TDATA};
        if (m_push) out_mem[out_wr_q] <= {acc_out_last, acc_out_data};
    end
endmodule

// File: tb/tb_axis_stream_fifo_if.sv
// Directed bench for axis_stream_fifo_if: drivers push expected beats into queues,
// a negedge monitor pops and compares on every output handshake.
module tb_axis_stream_fifo_if;
    localparam int W = 128;

    logic         aclk, arst_n;
    logic [W-1:0] s_tdata;
    logic         s_tvalid, s_tready, s_tlast;
    logic [W-1:0] acc_in_data;
    logic         acc_in_valid, acc_in_last, acc_in_ready;
    logic [W-1:0] acc_out_data;
    logic         acc_out_valid, acc_out_last, acc_out_ready;
    logic [W-1:0] m_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    logic [15:0]  in_frame_cnt, out_frame_cnt;
    logic         frame_err, err_clr;

    logic [W:0] exp_in_q[$];
    logic [W:0] exp_out_q[$];
    int checks = 0;
    int errors = 0;
    logic       m_stall;
    logic [W:0] m_held;
    bit         saw_full;

    axis_stream_fifo_if #(.DATA_WIDTH(W), .IN_DEPTH(4), .OUT_DEPTH(4), .FRAME_BEATS(16)) dut (
        .ACLK(aclk), .ARESETN(arst_n),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .S_AXIS_TLAST(s_tlast),
        .acc_in_data(acc_in_data), .acc_in_valid(acc_in_valid), .acc_in_last(acc_in_last),
        .acc_in_ready(acc_in_ready),
        .acc_out_data(acc_out_data), .acc_out_valid(acc_out_valid), .acc_out_last(acc_out_last),
        .acc_out_ready(acc_out_ready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TLAST(m_tlast),
        .in_frame_cnt(in_frame_cnt), .out_frame_cnt(out_frame_cnt),
        .frame_err(frame_err), .err_clr(err_clr)
    );

    // Clock and reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic s_beat(input logic [W-1:0] d, input logic l);
        int t = 0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_tready && t < 200) begin @(negedge aclk); t++; end
        if (!s_tready) check("s_beat_timeout", 0, 1);
        else exp_in_q.push_back({l, d});
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic a_beat(input logic [W-1:0] d, input logic l);
        int t = 0;
        acc_out_data = d; acc_out_last = l; acc_out_valid = 1'b1;
        @(negedge aclk);
        while (!acc_out_ready && t < 200) begin saw_full = 1'b1; @(negedge aclk); t++; end
        if (!acc_out_ready) check("a_beat_timeout", 0, 1);
        else exp_out_q.push_back({l, d});
        @(posedge aclk); #1;
        acc_out_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge aclk) begin
        if (!arst_n) begin
            m_stall = 1'b0;
        end else begin
            if (acc_in_valid && acc_in_ready) begin
                if (exp_in_q.size() == 0) check("acc_in_unexpected", {acc_in_last, acc_in_data}, '0);
                else check("acc_in_beat", {acc_in_last, acc_in_data}, exp_in_q.pop_front());
            end
            if (m_stall && m_tvalid) check("m_stable", {m_tlast, m_tdata}, m_held);
            if (m_tvalid && m_tready) begin
                if (exp_out_q.size() == 0) check("m_unexpected", {m_tlast, m_tdata}, '0);
                else check("m_beat", {m_tlast, m_tdata}, exp_out_q.pop_front());
            end
            m_stall = m_tvalid && !m_tready;
            m_held  = {m_tlast, m_tdata};
        end
    end

    initial begin
        int n;
        arst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        acc_in_ready = 1'b0; acc_out_data = '0; acc_out_valid = 1'b0; acc_out_last = 1'b0;
        m_tready = 1'b0; err_clr = 1'b0; m_stall = 1'b0; m_held = '0; saw_full = 1'b0;

        // Reset state
        #12;
        check("rst_s_tready", s_tready, 0);
        check("rst_acc_out_ready", acc_out_ready, 0);
        check("rst_acc_in_valid", acc_in_valid, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_in_frame_cnt", in_frame_cnt, 0);
        check("rst_out_frame_cnt", out_frame_cnt, 0);
        check("rst_frame_err", frame_err, 0);
        #11 arst_n = 1'b1;
        #1 check("tready_before_edge", s_tready, 0);
        wait_cycles(1);
        check("tready_after_edge", s_tready, 1);
        check("acc_out_ready_after_edge", acc_out_ready, 1);

        // Test 1: one good frame, consumer always ready
        acc_in_ready = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_beat(W'(i), i == 15);
            if (i == 0) begin
                check("first_latency_valid", acc_in_valid, 1);
                check("first_latency_data", acc_in_data, 0);
            end
        end
        check("t1_in_frame_cnt", in_frame_cnt, 1);
        check("t1_frame_err", frame_err, 0);
        wait_cycles(3);
        check("t1_drained", exp_in_q.size(), 0);

        // Test 2: backpressure fills the inbound FIFO
        acc_in_ready = 1'b0; s_tvalid = 1'b1; n = 0;
        for (int c = 0; c < 10; c++) begin
            s_tdata = W'(100 + n); s_tlast = 1'b0;
            @(negedge aclk);
            if (s_tready) begin exp_in_q.push_back({1'b0, s_tdata}); n++; end
            @(posedge aclk); #1;
        end
        check("t2_accepted", n, 4);
        check("t2_tready_low", s_tready, 0);
        acc_in_ready = 1'b1;
        wait_cycles(1);
        check("t2_tready_rise", s_tready, 1);
        s_tvalid = 1'b0;
        for (int i = 4; i < 16; i++) s_beat(W'(100 + i), i == 15);
        check("t2_in_frame_cnt", in_frame_cnt, 2);
        check("t2_frame_err", frame_err, 0);

        // Test 3: short frame, then good frame, then clear
        for (int i = 0; i < 10; i++) s_beat(W'(200 + i), i == 9);
        check("t3_short_err", frame_err, 1);
        check("t3_in_frame_cnt", in_frame_cnt, 3);
        for (int i = 0; i < 16; i++) s_beat(W'(300 + i), i == 15);
        check("t3_err_sticky", frame_err, 1);
        check("t3_in_frame_cnt2", in_frame_cnt, 4);
        err_clr = 1'b1;
        wait_cycles(1);
        err_clr = 1'b0;
        check("t3_err_cleared", frame_err, 0);

        // Test 4: 17-beat overrun, clear collides with the error
        for (int i = 0; i < 17; i++) begin
            if (i == 15) err_clr = 1'b1;
            s_beat(W'(400 + i), i == 16);
            err_clr = 1'b0;
            if (i == 14) check("t4_no_err_yet", frame_err, 0);
            if (i == 15) check("t4_err_wins", frame_err, 1);
        end
        check("t4_in_frame_cnt", in_frame_cnt, 5);

        // Test 5: master side with a toggling downstream ready
        saw_full = 1'b0;
        fork
            for (int i = 0; i < 8; i++) a_beat(W'(32'hA000 + i), i == 7);
            repeat (40) begin @(posedge aclk); #1 m_tready = ~m_tready; end
        join
        m_tready = 1'b1;
        wait_cycles(4);
        check("t5_saw_full", saw_full, 1);
        check("t5_out_frame_cnt", out_frame_cnt, 1);
        check("t5_drained", exp_out_q.size(), 0);

        // Test 6: asynchronous reset mid-frame with both FIFOs occupied
        acc_in_ready = 1'b0; m_tready = 1'b0;
        for (int i = 0; i < 3; i++) s_beat(W'(600 + i), 1'b0);
        for (int i = 0; i < 2; i++) a_beat(W'(700 + i), 1'b0);
        check("t6_in_nonempty", acc_in_valid, 1);
        check("t6_out_nonempty", m_tvalid, 1);
        #2 arst_n = 1'b0;
        #1;
        exp_in_q.delete();
        exp_out_q.delete();
        check("t6_s_tready", s_tready, 0);
        check("t6_acc_out_ready", acc_out_ready, 0);
        check("t6_acc_in_valid", acc_in_valid, 0);
        check("t6_m_tvalid", m_tvalid, 0);
        check("t6_in_frame_cnt", in_frame_cnt, 0);
        check("t6_out_frame_cnt", out_frame_cnt, 0);
        check("t6_frame_err", frame_err, 0);
        #1 arst_n = 1'b1;
        wait_cycles(1);
        check("t6_tready_back", s_tready, 1);
        acc_in_ready = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 16; i++) s_beat(W'(800 + i), i == 15);
        check("t6_frame_err_after", frame_err, 0);
        check("t6_in_frame_cnt_after", in_frame_cnt, 1);
        for (int i = 0; i < 2; i++) a_beat(W'(900 + i), i == 1);
        wait_cycles(4);
        check("t6_out_frame_cnt_after", out_frame_cnt, 1);

        wait_cycles(6);
        check("end_in_q_empty", exp_in_q.size(), 0);
        check("end_out_q_empty", exp_out_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_stream_fifo_if.md
Name: axis_stream_fifo_if

Overview:
- Parametrised successor to the accelerator's AXI-Stream data-path interface.
- Buffers inbound AXI-Stream beats in a slave-side FIFO and presents them to the accelerator core over a valid/ready port.
- Buffers core results in a master-side FIFO and drives them out on AXI-Stream.
- Checks inbound frame length against a fixed beat count and keeps frame counters for both directions.

Parameters:
DATA_WIDTH, 128, TDATA width and width of both core-side data ports
IN_DEPTH, 4, slave-side FIFO entries; power of 2, minimum 2
OUT_DEPTH, 4, master-side FIFO entries; power of 2, minimum 2
FRAME_BEATS, 16, expected beats per inbound frame, TLAST beat included; minimum 1

Ports:
ACLK  in  1  single clock; all logic is rising-edge
ARESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  DATA_WIDTH  inbound data
S_AXIS_TVALID  in  1  inbound valid
S_AXIS_TREADY  out  1  inbound ready
S_AXIS_TLAST  in  1  inbound end of frame
acc_in_data  out  DATA_WIDTH  data to core
acc_in_valid  out  1  data to core valid
acc_in_last  out  1  TLAST of the beat on acc_in_data
acc_in_ready  in  1  core accepts beat
acc_out_data  in  DATA_WIDTH  result data from core
acc_out_valid  in  1  result valid
acc_out_last  in  1  result end of frame
acc_out_ready  out  1  interface accepts result
M_AXIS_TDATA  out  DATA_WIDTH  outbound data
M_AXIS_TVALID  out  1  outbound valid
M_AXIS_TREADY  in  1  outbound ready
M_AXIS_TLAST  out  1  outbound end of frame
in_frame_cnt  out  16  inbound frames accepted (TLAST handshakes)
out_frame_cnt  out  16  outbound frames sent
frame_err  out  1  sticky inbound frame-length error
err_clr  in  1  synchronous clear of frame_err

Behaviour:
- Reset: ARESETN low clears immediately, independent of ACLK:
  - both FIFOs emptied; pointers and occupancy counts to 0
  - beat_idx to 0
  - counters and frame_err to 0
  - S_AXIS_TREADY, acc_out_ready, acc_in_valid and M_AXIS_TVALID all 0
- Ready after reset: TREADY and acc_out_ready rise on the first ACLK edge after ARESETN deasserts.
- Reset mid-frame: partial frames and buffered beats are discarded. No completion beat is emitted.
- FIFO structure: each FIFO stores {last, data} and uses a registered occupancy count.
  - Push = valid & ready on the input side; pop = valid & ready on the output side.
- Ready rules: S_AXIS_TREADY = (in_count != IN_DEPTH); acc_out_ready = (out_count != OUT_DEPTH).
  - Both are registered-count based, with no combinational path from downstream ready.
  - When full, no push occurs even if a pop happens in the same cycle.
- Output side is first-word-fall-through:
  - acc_in_valid = (in_count != 0); M_AXIS_TVALID = (out_count != 0).
  - Data and last are driven from the read-pointer entry.
- Latency: a beat pushed at edge k is valid at the output after edge k; minimum 1 cycle.
- Throughput: with the consumer always ready, 1 beat per cycle.
- Simultaneous push and pop when not full and not empty: count unchanged; both pointers advance.
- Pointers: log2(depth) bits, wrapping naturally.
- Stability: TDATA and TLAST on the master side must not change while TVALID=1 and TREADY=0 (guaranteed by FIFO storage).
- Frame check (slave side, per accepted S beat):
  - Non-last beat with beat_idx == FRAME_BEATS-1: set frame_err (overrun). beat_idx saturates at FRAME_BEATS-1.
  - TLAST beat with beat_idx != FRAME_BEATS-1: set frame_err (short or overrun frame).
  - TLAST beat in all cases: beat_idx to 0 and in_frame_cnt increments.
  - Other non-last beats: beat_idx increments.
  - Faulty frames are still forwarded unchanged.
- frame_err: sticky until err_clr=1 at an edge. If a new error and err_clr occur on the same edge, the error wins (frame_err stays 1).
- out_frame_cnt: increments on each M_AXIS handshake with TLAST=1.
- Counter width: both counters are 16 bits and wrap 0xFFFF to 0x0000.

Test Plan:
- Reset, then 16 beats with TDATA=i and TLAST on beat 15, acc_in_ready=1 → acc_in_data 0..15 in order, one per cycle, first beat 1 cycle after its handshake; acc_in_last on value 15 only; in_frame_cnt=1; frame_err=0.
- acc_in_ready=0 with TVALID held → TREADY falls after exactly IN_DEPTH=4 accepted beats. Raise ready → beats drain in order, no loss or duplication, TREADY rises the cycle after the first pop.
- Short frame: TLAST on beat 10 → frame_err=1, in_frame_cnt increments, beat_idx restarts. Next correct 16-beat frame → frame_err remains 1. err_clr pulse → frame_err=0.
- Overrun: 17 beats, TLAST on beat 17 → frame_err set at beat 16 handshake. err_clr asserted on that same edge → frame_err=1.
- Master side: core drives 8 results with last on result 8; M_AXIS_TREADY toggles 1/0 every cycle → M_AXIS data order and stability held while stalled; out_frame_cnt=1; acc_out_ready low when 4 entries are pending.
- ARESETN pulsed low mid-frame (asynchronous, between edges) with both FIFOs non-empty → all valids and readies drop immediately, counters read 0. Next full frame is processed with frame_err=0.
